mul_div_sequencer: RTL

Multi-cycle signed 32×32 multiply / 32÷32 divide unit that produces a 64-bit result and drives the load strobes of the 64-bit Z register. It sits between the datapath operand registers and the Z register. It writes the result with a fixed two-cycle sequence: Lo half first, then Hi half. Latency is constant, so the control unit can schedule it without polling.

---
 rtl/mul_div_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_sequencer
// Description : Multi-cycle signed WIDTHxWIDTH multiply / divide unit.
//               Multiply uses radix-2 Booth, one bit per cycle. Divide uses
//               restoring division on magnitudes followed by a sign fix-up.
//               Every operation has the same fixed latency. The 2*WIDTH-bit
//               result is written into the Z register in two beats: Lo half
//               first, then Hi half.
//
//               Optional feature macro: MULDIV_DIV_EN
//                 defined   - divide datapath and div_by_zero are present
//                 undefined - multiply only; a start with op_div=1 is ignored
//                             and div_by_zero is tied low
//
// Ports       : clk          - clock, rising edge
//               clr          - asynchronous active-high reset
//               start        - request, sampled only in IDLE
//               op_div       - 0 = multiply, 1 = divide (latched with start)
//               A, B         - signed operands (latched with start)
//               busy         - operation in progress (CALC, WR_LO, WR_HI)
//               done         - one-cycle pulse after the Hi write
//               div_by_zero  - pulses with done for a divide by zero
//               D            - registered 2*WIDTH-bit result bus
//               Z_input      - Z register write enable
//               Z_Lo_select  - write D[WIDTH-1:0] into Z Lo
//               Z_Hi_select  - write D[2*WIDTH-1:WIDTH] into Z Hi
//
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               op_div,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] D,
    output logic               Z_input,
    output logic               Z_Lo_select,
    output logic               Z_Hi_select
);

    localparam int                c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0]   c_CNT_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_WR_LO = 3'd2,
        S_WR_HI = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [c_CW-1:0]    r_cnt;

    // Shared iteration registers. Multiply: {acc, q, qm1} is the Booth
    // shift register (acc one bit wider so acc +/- M never overflows).
    // Divide: acc[WIDTH-1:0] is the partial remainder, q shifts the dividend
    // out and the quotient in.
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_q;
    logic               r_qm1;
    logic [WIDTH-1:0]   r_m;

    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH:0]     w_booth_sum;
    logic [WIDTH:0]     w_acc_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic               w_qm1_nx;
    logic [2*WIDTH-1:0] w_result;
    logic               w_accept;

    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic               r_z_in;
    logic               r_z_lo;
    logic               r_z_hi;

`ifdef MULDIV_DIV_EN
    logic               r_op_div;
    logic               r_a_neg;
    logic               r_b_neg;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;

    assign w_accept = start;
    assign w_a_mag  = A[WIDTH-1] ? -A : A;
    assign w_b_mag  = B[WIDTH-1] ? -B : B;
`else
    // Without the divider a divide request is simply not accepted.
    assign w_accept = start && !op_div;
`endif

    assign w_m_ext = {r_m[WIDTH-1], r_m};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nx = S_CALC;
            S_CALC:  if (r_cnt == c_CNT_LAST) w_state_nx = S_WR_LO;
            S_WR_LO: w_state_nx = S_WR_HI;
            S_WR_HI: w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ iteration step
    always_comb begin
        case ({r_q[0], r_qm1})
            2'b01:   w_booth_sum = r_acc + w_m_ext;
            2'b10:   w_booth_sum = r_acc - w_m_ext;
            default: w_booth_sum = r_acc;
        endcase
        // Arithmetic shift right of {sum, q, qm1}.
        w_acc_nx = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
        w_q_nx   = {w_booth_sum[0], r_q[WIDTH-1:1]};
        w_qm1_nx = r_q[0];
`ifdef MULDIV_DIV_EN
        w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_m};
        if (r_op_div) begin
            // Restore (keep the shifted remainder) when the trial goes negative.
            w_acc_nx = {1'b0, w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0]
                                                : w_div_diff[WIDTH-1:0]};
            w_q_nx   = {r_q[WIDTH-2:0], ~w_div_diff[WIDTH]};
            w_qm1_nx = 1'b0;
        end
`endif
    end

    // Final result, formed from the last step's next values so D can be
    // loaded on the same edge that leaves CALC.
    always_comb begin
        w_result = {w_acc_nx[WIDTH-1:0], w_q_nx};
`ifdef MULDIV_DIV_EN
        if (r_op_div) begin
            if (r_b_zero) begin
                w_result = {r_a, {WIDTH{1'b1}}};
            end else begin
                w_result[WIDTH-1:0]       = (r_a_neg ^ r_b_neg) ? -w_q_nx : w_q_nx;
                w_result[2*WIDTH-1:WIDTH] = r_a_neg ? -w_acc_nx[WIDTH-1:0]
                                                    : w_acc_nx[WIDTH-1:0];
            end
        end
`endif
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_m      <= '0;
            D        <= '0;
`ifdef MULDIV_DIV_EN
            r_op_div <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_a      <= '0;
`endif
        end else if (r_state == S_IDLE && w_accept) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_qm1    <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_op_div <= op_div;
            r_a_neg  <= A[WIDTH-1];
            r_b_neg  <= B[WIDTH-1];
            r_b_zero <= (B == '0);
            r_a      <= A;
            r_q      <= op_div ? w_a_mag : A;
            r_m      <= op_div ? w_b_mag : B;
`else
            r_q      <= A;
            r_m      <= B;
`endif
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
            r_qm1 <= w_qm1_nx;
            if (r_cnt == c_CNT_LAST) begin
                D <= w_result;
            end
        end
    end

    // --------------------------------------------------- registered outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            r_z_in <= 1'b0;
            r_z_lo <= 1'b0;
            r_z_hi <= 1'b0;
        end else begin
            r_busy <= (w_state_nx == S_CALC) || (w_state_nx == S_WR_LO) ||
                      (w_state_nx == S_WR_HI);
            r_done <= (w_state_nx == S_DONE);
            r_z_in <= (w_state_nx == S_WR_LO) || (w_state_nx == S_WR_HI);
            r_z_lo <= (w_state_nx == S_WR_LO);
            r_z_hi <= (w_state_nx == S_WR_HI);
`ifdef MULDIV_DIV_EN
            r_dbz  <= (w_state_nx == S_DONE) && r_op_div && r_b_zero;
`else
            r_dbz  <= 1'b0;
`endif
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign Z_input     = r_z_in;
    assign Z_Lo_select = r_z_lo;
    assign Z_Hi_select = r_z_hi;

endmodule
`default_nettype wire
